// File: rtl/mult_job_sched.sv
// Job controller for the processor412 multiply engine: round-robin arbitration of two requesters,
// operand write, start/ready handshake and product read-back. Define MULT_JOB_SCHED_TIMEOUT_EN for a WAIT timeout.
module mult_job_sched #(
  parameter logic [8:0] OPA_ADR    = 9'd0,
  parameter logic [8:0] OPB_ADR    = 9'd1,
  parameter logic [8:0] RES_LO_ADR = 9'd2,
  parameter logic [8:0] RES_HI_ADR = 9'd3
`ifdef MULT_JOB_SCHED_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT   = 4096
`endif
) (
  input  logic        ck,
  input  logic        rb,
  input  logic        req0_valid,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        req1_ready,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [63:0] rsp_prod,
  output logic        rsp_err,
  input  logic        rsp_ready,
  output logic        busy,
  output logic        p_start,
  input  logic        p_ready,
  output logic        p_dcen,
  output logic        p_dwen,
  output logic [8:0]  p_dadr,
  output logic [31:0] p_dinp,
  input  logic [31:0] p_dout
);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_WR_A  = 4'd1;
  localparam logic [3:0] S_WR_B  = 4'd2;
  localparam logic [3:0] S_START = 4'd3;
  localparam logic [3:0] S_WAIT  = 4'd4;
  localparam logic [3:0] S_RD_LO = 4'd5;
  localparam logic [3:0] S_RD_HI = 4'd6;
  localparam logic [3:0] S_CAP   = 4'd7;
  localparam logic [3:0] S_RESP  = 4'd8;

  logic [3:0]  state_q, state_d;
  logic [31:0] a_q, a_d, b_q, b_d, lo_q, lo_d, hi_q, hi_d;
  logic        id_q, id_d, last_q, last_d, prdy_q;
  logic        in_idle, gnt0, gnt1, rdy_rise;
`ifdef MULT_JOB_SCHED_TIMEOUT_EN
  localparam logic [12:0] TMO_LAST = 13'(TIMEOUT - 1);
  logic [12:0] cnt_q, cnt_d;
  logic        err_q, err_d;
`endif

  // last_q resets to 1 so requester 0 wins the first tie
  assign in_idle    = (state_q == S_IDLE);
  assign gnt0       = req0_valid & (~req1_valid | last_q);
  assign gnt1       = req1_valid & (~req0_valid | ~last_q);
  assign req0_ready = rb & in_idle & gnt0;
  assign req1_ready = rb & in_idle & gnt1;
  assign rdy_rise   = p_ready & ~prdy_q;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    id_d    = id_q;
    last_d  = last_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
`ifdef MULT_JOB_SCHED_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (gnt0 | gnt1) begin
          a_d     = gnt1 ? req1_a : req0_a;
          b_d     = gnt1 ? req1_b : req0_b;
          id_d    = gnt1;
          last_d  = gnt1;
          lo_d    = '0;
          hi_d    = '0;
`ifdef MULT_JOB_SCHED_TIMEOUT_EN
          err_d   = 1'b0;
`endif
          state_d = S_WR_A;
        end
      end
      S_WR_A:  state_d = S_WR_B;
      S_WR_B:  state_d = S_START;
      S_START: begin
        state_d = S_WAIT;
`ifdef MULT_JOB_SCHED_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      // only a fresh rise of p_ready counts; a level left over from the previous job is ignored
      S_WAIT: begin
        if (rdy_rise) begin
          state_d = S_RD_LO;
        end
`ifdef MULT_JOB_SCHED_TIMEOUT_EN
        else if (cnt_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d   = cnt_q + 13'd1;
        end
`endif
      end
      S_RD_LO: state_d = S_RD_HI;
      S_RD_HI: begin
        lo_d    = p_dout;
        state_d = S_CAP;
      end
      S_CAP: begin
        hi_d    = p_dout;
        state_d = S_RESP;
      end
      S_RESP:  if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ck or negedge rb) begin
    if (!rb) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      id_q    <= 1'b0;
      last_q  <= 1'b1;
      lo_q    <= '0;
      hi_q    <= '0;
      prdy_q  <= 1'b0;
`ifdef MULT_JOB_SCHED_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      id_q    <= id_d;
      last_q  <= last_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      prdy_q  <= p_ready;
`ifdef MULT_JOB_SCHED_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    p_dcen  = 1'b0;
    p_dwen  = 1'b0;
    p_dadr  = '0;
    p_dinp  = '0;
    p_start = 1'b0;
    case (state_q)
      S_WR_A: begin
        p_dcen = 1'b1;
        p_dwen = 1'b1;
        p_dadr = OPA_ADR;
        p_dinp = a_q;
      end
      S_WR_B: begin
        p_dcen = 1'b1;
        p_dwen = 1'b1;
        p_dadr = OPB_ADR;
        p_dinp = b_q;
      end
      S_START: p_start = 1'b1;
      S_RD_LO: begin
        p_dcen = 1'b1;
        p_dadr = RES_LO_ADR;
      end
      S_RD_HI: begin
        p_dcen = 1'b1;
        p_dadr = RES_HI_ADR;
      end
      default: ;
    endcase
  end

  assign busy      = ~in_idle;
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_id    = id_q;
  assign rsp_prod  = {hi_q, lo_q};
`ifdef MULT_JOB_SCHED_TIMEOUT_EN
  assign rsp_err   = err_q;
`else
  assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mult_job_sched.sv
// Bench for mult_job_sched: processor412/dmem model, queue-driven requesters and a
// job-level reference model (round-robin grant, product = a*b) checked every cycle.
module tb_mult_job_sched;

  typedef struct { logic [31:0] a; logic [31:0] b; } job_t;
  typedef struct { logic id; logic [63:0] prod; logic err; int cyc; } rsp_t;
  typedef struct { logic id; logic [31:0] a; logic [31:0] b; logic [63:0] prod; } vec_t;

  logic        ck = 1'b0, rb = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0, req0_ready, req1_ready;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        rsp_valid, rsp_id, rsp_err, rsp_ready = 1'b1, busy, p_start, p_ready;
  logic [63:0] rsp_prod;
  logic        p_dcen, p_dwen;
  logic [8:0]  p_dadr;
  logic [31:0] p_dinp, p_dout = '0;

  int checks = 0, errors = 0, cyc = 0;
  int edge_cyc = 0, rise_cyc = 0, start_cyc = 0;
  int pdelay = 5, pcnt = 0;
  logic prand = 0, proc_hang = 0, proc_rdy = 0, proc_busy = 0, stale_hold = 0, rsp_mode = 0;
  logic outstanding = 0, last_g = 1;
  logic [31:0] mem [512];
  job_t q0[$], q1[$];
  rsp_t got[$], expq[$];
  int rd_adr[$], rd_cyc[$];

  assign p_ready = proc_rdy | stale_hold;
  always #5 ck = ~ck;

`ifdef MULT_JOB_SCHED_TIMEOUT_EN
  mult_job_sched #(.TIMEOUT(16)) dut (
`else
  mult_job_sched dut (
`endif
    .ck(ck), .rb(rb),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_prod(rsp_prod), .rsp_err(rsp_err),
    .rsp_ready(rsp_ready), .busy(busy), .p_start(p_start), .p_ready(p_ready),
    .p_dcen(p_dcen), .p_dwen(p_dwen), .p_dadr(p_dadr), .p_dinp(p_dinp), .p_dout(p_dout)
  );

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endfunction

  // Environment: samples at negedge, updates processor/dmem and requesters 1 after posedge
  initial begin : env
    logic a0, a1, wr, rd, st, pr_prev, rv_prev, e0, e1;
    logic [8:0] adr;
    logic [31:0] din;
    logic [63:0] pr;
    rsp_t r;
    pr_prev = 0; rv_prev = 0;
    forever begin
      @(negedge ck);
      cyc++;
      if (!rb) begin
        outstanding = 0; last_g = 1; expq.delete(); pr_prev = 0; rv_prev = 0;
        continue;
      end
      a0 = req0_valid & req0_ready; a1 = req1_valid & req1_ready;
      wr = p_dcen & p_dwen; rd = p_dcen & ~p_dwen; st = p_start;
      adr = p_dadr; din = p_dinp;
      if (p_ready && !pr_prev) edge_cyc = cyc;
      if (rsp_valid && !rv_prev) rise_cyc = cyc;
      if (st) start_cyc = cyc;
      pr_prev = p_ready; rv_prev = rsp_valid;
      chk("dwen_without_dcen", {63'd0, p_dwen & ~p_dcen}, 64'd0);
      e0 = !outstanding & req0_valid & (!req1_valid | last_g);
      e1 = !outstanding & req1_valid & (!req0_valid | !last_g);
      chk("req0_ready", {63'd0, req0_ready}, {63'd0, e0});
      chk("req1_ready", {63'd0, req1_ready}, {63'd0, e1});
      chk("rsp_valid_without_job", {63'd0, rsp_valid & !outstanding}, 64'd0);
      if (rd) begin rd_adr.push_back(int'(adr)); rd_cyc.push_back(cyc); end
      if (rsp_valid && rsp_ready) begin
        r.id = rsp_id; r.prod = rsp_prod; r.err = rsp_err; r.cyc = cyc;
        got.push_back(r);
        if (expq.size() == 0) chk("unexpected_rsp", 64'd1, 64'd0);
        else begin
          r = expq.pop_front();
          chk("model_rsp_id", {63'd0, rsp_id}, {63'd0, r.id});
          chk("model_rsp_prod", rsp_prod, r.prod);
          chk("model_rsp_err", {63'd0, rsp_err}, {63'd0, r.err});
        end
        outstanding = 0;
      end
      if (a0 | a1) begin
        outstanding = 1; last_g = a1;
        r.id = a1; r.err = proc_hang; r.cyc = cyc;
        r.prod = proc_hang ? 64'd0 : (a1 ? 64'(req1_a) * 64'(req1_b) : 64'(req0_a) * 64'(req0_b));
        expq.push_back(r);
      end
      @(posedge ck); #1;
      if (!rb) continue;
      if (wr) mem[adr] = din;
      if (rd) p_dout = mem[adr];
      if (st) begin
        proc_rdy = 0; proc_busy = 1;
        pcnt = prand ? int'($urandom_range(1, 8)) : pdelay;
      end else if (proc_busy && !proc_hang) begin
        if (pcnt <= 1) begin
          pr = 64'(mem[0]) * 64'(mem[1]);
          mem[2] = pr[31:0]; mem[3] = pr[63:32];
          proc_rdy = 1; proc_busy = 0;
        end else pcnt--;
      end
      if (a0) void'(q0.pop_front());
      if (a1) void'(q1.pop_front());
      req0_valid = (q0.size() > 0);
      if (q0.size() > 0) begin req0_a = q0[0].a; req0_b = q0[0].b; end
      req1_valid = (q1.size() > 0);
      if (q1.size() > 0) begin req1_a = q1[0].a; req1_b = q1[0].b; end
      if (rsp_mode) rsp_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic wait_got(input int n, input int bound, input string nm);
    int k = 0;
    while (got.size() < n && k < bound) begin @(negedge ck); k++; end
    checks++;
    if (got.size() < n) begin
      errors++;
      $display("FAIL %s: responses %0d required %0d within %0d cycles", nm, got.size(), n, bound);
    end
  endtask

  task automatic wait_start(input string nm);
    int k = 0;
    while (p_start !== 1'b1 && k < 60) begin @(negedge ck); k++; end
    chk(nm, {63'd0, p_start}, 64'd1);
  endtask

  task automatic push(input logic id, input logic [31:0] a, input logic [31:0] b);
    job_t j;
    j.a = a; j.b = b;
    if (id) q1.push_back(j); else q0.push_back(j);
  endtask

  task automatic chk_idle_outputs(input string nm);
    chk({nm, "_ctl"}, {55'd0, busy, rsp_valid, rsp_err, rsp_id, p_start, p_dcen, p_dwen, req0_ready, req1_ready}, 64'd0);
    chk({nm, "_prod"}, rsp_prod, 64'd0);
    chk({nm, "_dadr"}, {55'd0, p_dadr}, 64'd0);
    chk({nm, "_dinp"}, {32'd0, p_dinp}, 64'd0);
  endtask

  task automatic run_vec(input vec_t v);
    int n, k;
    n = got.size(); k = 0;
    @(negedge ck);
    push(v.id, v.a, v.b);
    while (!(v.id ? (req1_valid & req1_ready) : (req0_valid & req0_ready)) && k < 60) begin
      @(negedge ck); k++;
    end
    chk("vec_accept", {63'd0, v.id ? req1_ready : req0_ready}, 64'd1);
    @(negedge ck);
    chk("vec_wr_a_ctl", {61'd0, p_dcen, p_dwen, p_start}, 64'd6);
    chk("vec_wr_a_adr", {55'd0, p_dadr}, 64'd0);
    chk("vec_wr_a_dat", {32'd0, p_dinp}, {32'd0, v.a});
    @(negedge ck);
    chk("vec_wr_b_ctl", {61'd0, p_dcen, p_dwen, p_start}, 64'd6);
    chk("vec_wr_b_adr", {55'd0, p_dadr}, 64'd1);
    chk("vec_wr_b_dat", {32'd0, p_dinp}, {32'd0, v.b});
    @(negedge ck);
    chk("vec_start", {61'd0, p_dcen, p_dwen, p_start}, 64'd1);
    @(negedge ck);
    chk("vec_wait_idle_port", {p_dcen, p_dwen, p_start, 52'd0, p_dadr}, 64'd0);
    wait_got(n + 1, 100, "vec_rsp");
    if (got.size() > n) begin
      chk("vec_rsp_id", {63'd0, got[n].id}, {63'd0, v.id});
      chk("vec_rsp_prod", got[n].prod, v.prod);
      chk("vec_rsp_err", {63'd0, got[n].err}, 64'd0);
      chk("vec_latency", 64'(rise_cyc - edge_cyc), 64'd4);
    end
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin : test
    vec_t vt [5];
    int n, r;
    logic [63:0] hold_prod;
    logic hold_id;
    vt[0] = '{id: 1'b0, a: 32'h1F142570, b: 32'h001200C2, prod: 64'h00022F82_2F245EE0};
    vt[1] = '{id: 1'b1, a: 32'h00000000, b: 32'hDEADBEEF, prod: 64'h0};
    vt[2] = '{id: 1'b0, a: 32'h80000000, b: 32'h00000002, prod: 64'h00000001_00000000};
    vt[3] = '{id: 1'b1, a: 32'h12345678, b: 32'h00000010, prod: 64'h00000001_23456780};
    vt[4] = '{id: 1'b1, a: 32'hFFFFFFFF, b: 32'h00000001, prod: 64'h00000000_FFFFFFFF};

    // reset state, with a requester already asserting valid
    req0_valid = 1'b1;
    repeat (3) @(posedge ck);
    #1 chk_idle_outputs("reset");
    req0_valid = 1'b0;
    @(negedge ck) rb = 1'b1;

    // tie, then a second simultaneous pair that must go to requester 1
    @(negedge ck);
    n = got.size();
    push(0, 32'hFFFFFFFF, 32'hFFFFFFFF); push(0, 32'd7, 32'd9); push(1, 32'd2, 32'd3);
    wait_got(n + 3, 300, "tie_rsp");
    if (got.size() >= n + 3) begin
      chk("tie_first_id", {63'd0, got[n].id}, 64'd0);
      chk("tie_first_prod", got[n].prod, 64'hFFFFFFFE_00000001);
      chk("tie_second_id", {63'd0, got[n+1].id}, 64'd1);
      chk("tie_second_prod", got[n+1].prod, 64'h6);
      chk("tie_third_id", {63'd0, got[n+2].id}, 64'd0);
      chk("tie_third_prod", got[n+2].prod, 64'h3F);
    end

    for (int i = 0; i < 5; i++) run_vec(vt[i]);

    // backpressure
    @(posedge ck); #1 rsp_ready = 1'b0;
    @(negedge ck);
    n = got.size();
    push(0, 32'd3, 32'd5); push(1, 32'd4, 32'd6); push(0, 32'd8, 32'd8);
    r = 0;
    while (!rsp_valid && r < 60) begin @(negedge ck); r++; end
    chk("bp_rsp_valid", {63'd0, rsp_valid}, 64'd1);
    hold_prod = rsp_prod; hold_id = rsp_id;
    chk("bp_first_prod", hold_prod, 64'd15);
    for (int i = 0; i < 20; i++) begin
      @(negedge ck);
      chk("bp_hold_valid", {63'd0, rsp_valid}, 64'd1);
      chk("bp_hold_prod", rsp_prod, hold_prod);
      chk("bp_hold_id", {63'd0, rsp_id}, {63'd0, hold_id});
      chk("bp_no_grant", {62'd0, req0_ready, req1_ready}, 64'd0);
    end
    @(posedge ck); #1 rsp_ready = 1'b1;
    @(negedge ck);
    @(negedge ck);
    chk("bp_release_idle", {62'd0, busy, rsp_valid}, 64'd0);
    wait_got(n + 3, 200, "bp_drain");

    // stale p_ready: held high across START into WAIT
    @(negedge ck);
    stale_hold = 1; pdelay = 12;
    n = got.size(); r = rd_adr.size();
    push(1, 32'h11, 32'h13);
    wait_start("stale_start");
    repeat (6) @(negedge ck);
    chk("stale_no_read", 64'(rd_adr.size()), 64'(r));
    @(posedge ck); #1 stale_hold = 0;
    wait_got(n + 1, 100, "stale_rsp");
    chk("stale_read_count", 64'(rd_adr.size()), 64'(r + 2));
    if (rd_adr.size() >= r + 2) begin
      chk("stale_read_lo_adr", 64'(rd_adr[r]), 64'd2);
      chk("stale_read_hi_adr", 64'(rd_adr[r+1]), 64'd3);
      chk("stale_read_consecutive", 64'(rd_cyc[r+1] - rd_cyc[r]), 64'd1);
    end
    if (got.size() > n) chk("stale_prod", got[n].prod, 64'h143);

    // reset in the middle of WAIT
    pdelay = 20;
    @(negedge ck);
    n = got.size();
    push(0, 32'd5, 32'd7);
    wait_start("rst_start");
    repeat (3) @(negedge ck);
    @(posedge ck); #3 rb = 1'b0;
    #1 chk_idle_outputs("midrst");
    @(posedge ck); #3 rb = 1'b1;
    repeat (30) @(negedge ck);
    chk("midrst_no_rsp", 64'(got.size()), 64'(n));
    pdelay = 4;
    push(1, 32'd6, 32'd7);
    wait_got(n + 1, 100, "midrst_next_rsp");
    if (got.size() > n) begin
      chk("midrst_next_id", {63'd0, got[n].id}, 64'd1);
      chk("midrst_next_prod", got[n].prod, 64'd42);
    end

    // randomized traffic with random backpressure and processor latency
    rsp_mode = 1; prand = 1;
    n = got.size();
    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge ck);
      push(1'($urandom_range(0, 1)), $urandom, $urandom);
    end
    wait_got(n + 30, 4000, "rand_rsp");
    rsp_mode = 0; prand = 0; pdelay = 5;
    @(posedge ck); #1 rsp_ready = 1'b1;

`ifdef MULT_JOB_SCHED_TIMEOUT_EN
    // processor never answers
    @(negedge ck);
    proc_hang = 1;
    n = got.size(); r = rd_adr.size();
    push(0, 32'd9, 32'd9);
    wait_got(n + 1, 200, "tmo_rsp");
    if (got.size() > n) begin
      chk("tmo_err", {63'd0, got[n].err}, 64'd1);
      chk("tmo_prod", got[n].prod, 64'd0);
      chk("tmo_latency", 64'(rise_cyc - start_cyc), 64'd17);
    end
    chk("tmo_no_reads", 64'(rd_adr.size()), 64'(r));
    proc_hang = 0;
`endif

    repeat (3) @(negedge ck);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_job_sched.md
Name: mult_job_sched

Overview:
- Job controller and arbiter for the processor412 multiply engine.
- Accepts 32x32 multiply jobs from two requesters and round-robin arbitrates between them.
- For each job: writes the operands into processor dmem, pulses start, waits for ready, reads the 64-bit product back, and returns it with the requester ID.
- Sits between host-side requesters and processor412's start/ready and dmem port.

Parameters:
- OPA_ADR, 9'd0, dmem address of multiplicand
- OPB_ADR, 9'd1, dmem address of multiplier
- RES_LO_ADR, 9'd2, dmem address of product low word
- RES_HI_ADR, 9'd3, dmem address of product high word
- TIMEOUT, 4096, cycles to wait for p_ready before abort (used only with the optional feature)

Ports:
- ck  in  1  clock, rising edge
- rb  in  1  reset, asynchronous, active-low
- req0_valid  in  1  requester 0 has a job
- req0_a  in  32  requester 0 operand A
- req0_b  in  32  requester 0 operand B
- req0_ready  out  1  requester 0 job accepted this cycle
- req1_valid / req1_a / req1_b / req1_ready  same as requester 0, for requester 1
- rsp_valid  out  1  result available
- rsp_id  out  1  requester that owns the result
- rsp_prod  out  64  {hi, lo} product
- rsp_err  out  1  job aborted (timeout)
- rsp_ready  in  1  consumer takes result
- busy  out  1  state != IDLE
- p_start  out  1  to processor start
- p_ready  in  1  from processor ready
- p_dcen  out  1  dmem chip enable
- p_dwen  out  1  dmem write enable
- p_dadr  out  9  dmem address
- p_dinp  out  32  dmem write data
- p_dout  in  32  dmem read data, valid 1 cycle after read enable

Behaviour:
- Reset: async on rb=0. State IDLE. All outputs 0, including rsp_prod, p_dadr and p_dinp. Round-robin pointer set so req0 wins the first tie. p_ready edge register cleared.
- Reset mid-job: job discarded, no response issued, dmem contents undefined.
- IDLE:
  - reqN_ready is combinational: high only for the granted valid requester, and only in IDLE.
  - Both valid: grant the requester other than the last granted.
  - On accept: latch a, b and id; update pointer; go to WR_A.
- WR_A: dcen=1, dwen=1, dadr=OPA_ADR, dinp=a. Go to WR_B.
- WR_B: dcen=1, dwen=1, dadr=OPB_ADR, dinp=b. Go to START.
- START: dcen=0, dwen=0, p_start=1 for exactly 1 cycle. Go to WAIT.
- WAIT:
  - dmem port idle: dcen=0, dadr=0, dinp=0.
  - Register ready_q <= p_ready each cycle.
  - Rising edge (p_ready & ~ready_q) moves to RD_LO.
  - p_ready already high on WAIT entry is not an edge; the block waits for a fresh rise.
- RD_LO: dcen=1, dwen=0, dadr=RES_LO_ADR. Go to RD_HI.
- RD_HI: dcen=1, dadr=RES_HI_ADR; capture p_dout into lo. Go to CAP.
- CAP: dcen=0; capture p_dout into hi. Go to RESP.
- RESP:
  - rsp_valid=1; rsp_id, rsp_prod and rsp_err stable until rsp_ready.
  - On rsp_valid & rsp_ready: go to IDLE. rsp_valid drops the next cycle.
  - Backpressure holds indefinitely; no new grant while in RESP.
- Latency: accept cycle T, p_start at T+3. If the ready edge is seen at cycle W, rsp_valid rises at W+4.
- Requests arriving while busy see reqN_ready=0 and must hold valid. Valid may drop before grant without effect.
- dwen is never high when dcen is low.
- The block does no arithmetic; the product is exactly the dmem words, unmodified.

Optional Feature:
- Macro: MULT_JOB_SCHED_TIMEOUT_EN
- Defined:
  - A 13-bit counter clears on WAIT entry and increments each WAIT cycle.
  - Reaching TIMEOUT-1 without a ready edge skips the reads and enters RESP with rsp_err=1 and rsp_prod=0.
  - The counter is reset async with rb.
- Undefined: WAIT has no limit, rsp_err is tied 0, and no counter logic exists.

Test Plan:
- Single job: req0 a=0x1F142570, b=0x001200C2 with processor412 model.
  - Required: dmem[0..1] written in 2 consecutive cycles, then one start pulse.
  - Required: rsp_id=0, rsp_prod=0x00022F82_2F245EE0, rsp_err=0.
- Tie: both valid in the same cycle, req0 a=b=0xFFFFFFFF, req1 a=2, b=3.
  - Required: req0 served first with 0xFFFFFFFE_00000001.
  - Required: then req1 with 0x00000000_00000006.
  - Required: a second simultaneous pair is granted req1 first.
- Backpressure: rsp_ready held low for 20 cycles.
  - Required: rsp_valid, rsp_prod and rsp_id stable; req0_ready and req1_ready stay 0.
  - Required: release → IDLE the next cycle.
- Stale ready: p_ready held high before START.
  - Required: no reads issued until p_ready falls and rises again.
  - Required: read addresses 2 then 3 on consecutive cycles.
- Reset mid-WAIT: rb low for 1 cycle.
  - Required: all outputs 0 immediately, no rsp_valid, next job completes correctly.
- With MULT_JOB_SCHED_TIMEOUT_EN and TIMEOUT=16, p_ready never rises.
  - Required: rsp_valid with rsp_err=1 and rsp_prod=0, 16 cycles after WAIT entry.
  - Required: no dmem reads.
